// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: logs every change of the CPU GPIO word over an 8N1 UART line.
// Each changed word is queued in a small FIFO and sent as four bytes, least
// significant byte first. Compile-time option GPIO_UART_SYNC_EN prefixes every
// word with a 0xA5 sync byte (five bytes per word).
`timescale 1ns/1ps
module gpio_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [31:0]                   GPIO,
   output logic                          TX,
   output logic                          BUSY,
   output logic                          OVERFLOW,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef GPIO_UART_SYNC_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [31:0]      gpio_q;
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push, pop, push_ok, full, empty;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic [2:0]       byte_idx, byte_idx_d;
   logic [31:0]      shreg, shreg_d;
   logic [7:0]       byte_d;
   logic             tx_d;

   // A change is any difference from last cycle's sampled word.
   assign push    = (GPIO != gpio_q);
   assign empty   = (FIFO_LEVEL == '0);
   assign full    = (FIFO_LEVEL == LVL_W'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
   assign push_ok = push && (!full || pop);

   // Change detector, FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gpio_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         FIFO_LEVEL <= '0;
         OVERFLOW   <= 1'b0;
      end else begin
         gpio_q <= GPIO;
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         FIFO_LEVEL <= FIFO_LEVEL + LVL_W'(push_ok) - LVL_W'(pop);
         if (push && !push_ok) OVERFLOW <= 1'b1;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= GPIO;
   end

   // TX FSM state register; TX and BUSY are registered from next-state values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         TX       <= 1'b1;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         bit_idx  <= bit_idx_d;
         byte_idx <= byte_idx_d;
         shreg    <= shreg_d;
         TX       <= tx_d;
         BUSY     <= (state_d != IDLE);
      end
   end

   // Next-state, baud counting, FIFO pop and next TX level.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt + CNT_W'(1);
      bit_idx_d  = bit_idx;
      byte_idx_d = byte_idx;
      shreg_d    = shreg;
      pop        = 1'b0;
      byte_d     = 8'h00;
      tx_d       = 1'b1;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop        = 1'b1;
               shreg_d    = mem[rd_ptr];
               byte_idx_d = '0;
               state_d    = START;
            end
         end
         START: begin
            if (cnt == CNT_MAX) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_MAX) begin
               cnt_d = '0;
               if (bit_idx == 3'd7) state_d = STOP;
               else                 bit_idx_d = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == CNT_MAX) begin
               cnt_d = '0;
               if (byte_idx < LAST_BYTE) begin
                  byte_idx_d = byte_idx + 3'd1;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Byte on the wire for the upcoming cycle, little-endian order.
`ifdef GPIO_UART_SYNC_EN
      case (byte_idx_d)
         3'd0:    byte_d = 8'hA5;
         3'd1:    byte_d = shreg_d[7:0];
         3'd2:    byte_d = shreg_d[15:8];
         3'd3:    byte_d = shreg_d[23:16];
         default: byte_d = shreg_d[31:24];
      endcase
`else
      case (byte_idx_d)
         3'd0:    byte_d = shreg_d[7:0];
         3'd1:    byte_d = shreg_d[15:8];
         3'd2:    byte_d = shreg_d[23:16];
         default: byte_d = shreg_d[31:24];
      endcase
`endif

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = byte_d[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expectations adapt to GPIO_UART_SYNC_EN (five bytes per word when defined).
`timescale 1ns/1ps
module tb_gpio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef GPIO_UART_SYNC_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int WORD_CYC = 10 * CPB * NB;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] GPIO;
   logic        TX, BUSY, OVERFLOW;
   logic [2:0]  FIFO_LEVEL;

   int          tests = 0;
   int          fails = 0;
   int          busy_cnt = 0;
   logic        tx_log[$];
   logic [7:0]  byte_q[$];
   logic [7:0]  exp_q[$];

   logic [31:0] burst [6] = '{32'h11111111, 32'h22222222, 32'hDEADBEEF,
                              32'h00000001, 32'h80000000, 32'h0F0F0F0F};
   logic [31:0] fill  [6] = '{32'hA0A0A0A0, 32'h01020304, 32'hCAFEBABE,
                              32'h7F7F0000, 32'h00FF00FF, 32'h13579BDF};

   gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .GPIO       (GPIO),
      .TX         (TX),
      .BUSY       (BUSY),
      .OVERFLOW   (OVERFLOW),
      .FIFO_LEVEL (FIFO_LEVEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Record TX and BUSY at n consecutive falling edges.
   task automatic sample(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         tx_log.push_back(TX);
         if (BUSY) busy_cnt++;
      end
   endtask

   // Decode 8N1 frames from the per-cycle TX record, sampling mid-bit.
   task automatic decode();
      int i;
      logic [7:0] b;
      byte_q.delete();
      i = 0;
      while (i + 10 * CPB <= tx_log.size()) begin
         if (tx_log[i] == 1'b0) begin
            for (int k = 0; k < 8; k++) b[k] = tx_log[i + CPB * (k + 1) + CPB / 2];
            check("stop_bit", 32'(tx_log[i + 9 * CPB + CPB / 2]), 32'd1);
            byte_q.push_back(b);
            i += 10 * CPB;
         end else begin
            i++;
         end
      end
   endtask

   task automatic add_word(input logic [31:0] w);
`ifdef GPIO_UART_SYNC_EN
      exp_q.push_back(8'hA5);
`endif
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8 * k +: 8]);
   endtask

   task automatic compare_bytes(input string tag);
      check({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      // Reset held with GPIO toggling: outputs must stay at reset values.
      RST_N = 1'b0;
      GPIO  = 32'h0;
      for (int c = 0; c < 6; c++) begin
         GPIO = $urandom;
         @(negedge CLK);
         check("rst_tx",   32'(TX),         32'd1);
         check("rst_busy", 32'(BUSY),       32'd0);
         check("rst_lvl",  32'(FIFO_LEVEL), 32'd0);
         check("rst_ovf",  32'(OVERFLOW),   32'd0);
      end
      GPIO = 32'h0;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      check("idle_tx",  32'(TX),         32'd1);
      check("idle_lvl", 32'(FIFO_LEVEL), 32'd0);

      // Single change: start bit two edges after the change.
      tx_log.delete(); busy_cnt = 0;
      GPIO = 32'h12345678;
      sample(1);
      check("t2_tx_e",    32'(TX),         32'd1);
      check("t2_lvl_e",   32'(FIFO_LEVEL), 32'd1);
      check("t2_busy_e",  32'(BUSY),       32'd0);
      sample(1);
      check("t2_tx_e1",   32'(TX),         32'd0);
      check("t2_lvl_e1",  32'(FIFO_LEVEL), 32'd0);
      check("t2_busy_e1", 32'(BUSY),       32'd1);
      sample(WORD_CYC + 20);
      check("t2_busy_cycles", 32'(busy_cnt), 32'(WORD_CYC));
      decode();
      exp_q.delete(); add_word(32'h12345678);
      compare_bytes("t2");

      // Burst of six changes: one popped, four buffered, last dropped.
      tx_log.delete(); exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         GPIO = burst[i];
         sample(1);
         if (i == 4) check("t3_ovf_before", 32'(OVERFLOW), 32'd0);
      end
      check("t3_ovf", 32'(OVERFLOW),   32'd1);
      check("t3_lvl", 32'(FIFO_LEVEL), 32'd4);
      sample(5 * (WORD_CYC + 1) + 40);
      decode();
      for (int i = 0; i < 5; i++) add_word(burst[i]);
      compare_bytes("t3");
      check("t3_ovf_sticky", 32'(OVERFLOW), 32'd1);

      // Full FIFO with push on the exact pop edge.
      RST_N = 1'b0; GPIO = 32'h0;
      @(negedge CLK);
      check("t4_rst_ovf", 32'(OVERFLOW),   32'd0);
      check("t4_rst_lvl", 32'(FIFO_LEVEL), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 5; i++) begin
         GPIO = fill[i];
         @(negedge CLK);
      end
      check("t4_full_lvl", 32'(FIFO_LEVEL), 32'd4);
      check("t4_full_ovf", 32'(OVERFLOW),   32'd0);
      repeat (WORD_CYC - 3) @(negedge CLK);
      check("t4_gap_busy", 32'(BUSY),       32'd0);
      check("t4_gap_lvl",  32'(FIFO_LEVEL), 32'd4);
      GPIO = fill[5];
      tx_log.delete(); exp_q.delete();
      sample(1);
      check("t4_pop_lvl",  32'(FIFO_LEVEL), 32'd4);
      check("t4_pop_ovf",  32'(OVERFLOW),   32'd0);
      check("t4_pop_busy", 32'(BUSY),       32'd1);
      check("t4_pop_tx",   32'(TX),         32'd0);
      sample(5 * (WORD_CYC + 1) + 20);
      decode();
      for (int i = 1; i < 6; i++) add_word(fill[i]);
      compare_bytes("t4");
      check("t4_end_ovf", 32'(OVERFLOW), 32'd0);

      // Reset in the middle of the third byte's data bits.
      GPIO = 32'h5A0000E1;
      @(negedge CLK);
      @(negedge CLK);
      check("t5_start", 32'(TX), 32'd0);
      GPIO = 32'h0BADCAFE;
      repeat (90) @(negedge CLK);
      check("t5_pre_tx",   32'(TX),         32'd0);
      check("t5_pre_busy", 32'(BUSY),       32'd1);
      check("t5_pre_lvl",  32'(FIFO_LEVEL), 32'd1);
      RST_N = 1'b0;
      #1;
      check("t5_async_tx",   32'(TX),         32'd1);
      check("t5_async_lvl",  32'(FIFO_LEVEL), 32'd0);
      check("t5_async_busy", 32'(BUSY),       32'd0);
      @(negedge CLK);
      check("t5_hold_tx", 32'(TX), 32'd1);
      RST_N = 1'b1;
      tx_log.delete(); exp_q.delete();
      sample(WORD_CYC + 30);
      decode();
      add_word(32'h0BADCAFE);
      compare_bytes("t5");
      check("t5_ovf", 32'(OVERFLOW), 32'd0);

      // Word 0x000000FF (sync byte first when the option is built in).
      GPIO = 32'h000000FF;
      tx_log.delete(); exp_q.delete(); busy_cnt = 0;
      sample(WORD_CYC + 20);
      check("t6_busy_cycles", 32'(busy_cnt), 32'(WORD_CYC));
      decode();
      add_word(32'h000000FF);
      compare_bytes("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpio_uart_tx.md
# gpio_uart_tx

GPIO change-logging UART transmitter. Sits directly downstream of the CPU's 32-bit `GPIO` output in the top-level design. It detects every change of the GPIO word, buffers changed values in a small FIFO, and serialises each value as four 8N1 UART bytes on a single `TX` line. It gives off-chip visibility of program output without touching the CPU, ROM or RAM.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: CLK cycles per UART bit. Legal values are ≥ 2.
- `FIFO_DEPTH`, default 4: number of 32-bit words buffered. Must be a power of two, ≥ 2.

Ports:
- `CLK`, input, 1 bit: system clock. All logic is on the rising edge.
- `RST_N`, input, 1 bit: reset. Asynchronous, active-low.
- `GPIO`, input, 32 bits: CPU GPIO output word.
- `TX`, output, 1 bit: UART serial out. Idles high.
- `BUSY`, output, 1 bit: high while a word is being shifted out.
- `OVERFLOW`, output, 1 bit: sticky flag. Set when a change is dropped because the FIFO is full.
- `FIFO_LEVEL`, output, $clog2(FIFO_DEPTH)+1 bits: number of words currently stored.

## Operation
- **Change detector:** `gpio_q` registers `GPIO` every cycle. Reset value is 0.
  - `push` = (`GPIO` != `gpio_q`).
  - A GPIO value that is non-zero when reset is released produces one push.
- **FIFO:** circular buffer with read pointer, write pointer and count.
  - The push writes the current `GPIO` value.
  - A push while full is dropped and sets `OVERFLOW`. Only `RST_N` clears `OVERFLOW`.
  - Push while full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Push while empty: there is no bypass. The word becomes poppable on the next cycle.
- **TX FSM** has four states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: `TX`=1. If the FIFO is non-empty, pop the head into a 32-bit shift word, set byte index = 0 and go to `START`.
  - `START`: `TX`=0 for `CLKS_PER_BIT` cycles, then go to `DATA`.
  - `DATA`: send 8 bits, LSB first, for `CLKS_PER_BIT` cycles each, then go to `STOP`.
  - `STOP`: `TX`=1 for `CLKS_PER_BIT` cycles. Then:
    - if byte index < 3: increment it and go to `START`;
    - otherwise go to `IDLE`.
  - Byte order is little-endian: `GPIO[7:0]` first, `GPIO[31:24]` last.
- The baud counter counts 0..`CLKS_PER_BIT`-1. It is cleared on every state entry.
- `BUSY` = (state != `IDLE`).

## Timing
- Reset values:
  - `TX`=1, `BUSY`=0, `OVERFLOW`=0, `FIFO_LEVEL`=0.
  - State = `IDLE`, pointers and `gpio_q` = 0.
- Assertion of `RST_N` takes effect immediately, mid-frame included. `TX` returns high and all buffered words are discarded.
- Latency from a GPIO change to the start bit, with the FIFO empty and the FSM in `IDLE`:
  - edge E samples the change and pushes the word;
  - edge E+1 pops it and drives `TX`=0.
  - `TX` is therefore low in the cycle after E+1.
- `TX`, `BUSY`, `OVERFLOW` and `FIFO_LEVEL` are all registered outputs.
- Word duration is 40 × `CLKS_PER_BIT` cycles (50 × with the macro). There is no idle gap between bytes of one word.
- Back-to-back words: the `STOP` of the last byte is followed by one `IDLE` cycle, then the next pop.
- A GPIO change every cycle pushes a word every cycle until the FIFO is full.

## Configuration
- `GPIO_UART_SYNC_EN`:
  - **Defined:** every word is preceded by a sync byte 0xA5. The byte index runs 0..4, with index 0 = 0xA5, then the four GPIO bytes in the same order.
  - **Undefined:** four bytes per word. No sync logic is synthesised.

## Test plan
Run the bench with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. **Reset:** hold `RST_N`=0 with GPIO toggling. Require `TX`=1, `BUSY`=0, `FIFO_LEVEL`=0 and `OVERFLOW`=0 throughout.
2. **Single change:** drive GPIO 0 → 0x12345678.
   - Decode the bytes 0x78, 0x56, 0x34, 0x12 in that order, each an 8N1 frame of 40 cycles.
   - `BUSY` is high for 160 cycles. `TX` goes low 2 edges after the change.
3. **Burst:** drive 6 distinct values on consecutive cycles while idle.
   - The first is popped immediately and 4 are buffered; the 6th is dropped.
   - Require `OVERFLOW`=1 and 5 words transmitted in push order.
4. **Full + simultaneous pop:** with the FIFO full, push on the exact cycle the FSM pops. Require the word to be accepted, `FIFO_LEVEL` to stay 4 and `OVERFLOW` to stay 0.
5. **Reset mid-frame:** pull `RST_N` low during `DATA` of byte 2.
   - `TX`=1 is required asynchronously before the next edge, and `FIFO_LEVEL`=0.
   - After release with GPIO unchanged and non-zero, exactly one word is retransmitted.
6. **Sync variant** (`GPIO_UART_SYNC_EN`): drive GPIO → 0x000000FF. Require the bytes 0xA5, 0xFF, 0x00, 0x00, 0x00, with `BUSY` high for 200 cycles.
